// File: rtl/btn_step_decoder.sv
// btn_step_decoder: debounces two active-low push-buttons and turns each
// debounced press into a single-cycle step_up / step_dn pulse.
// Optional feature macro: AUTO_REPEAT_EN. When it is defined, holding a
// button emits extra steps, first after RPT_DLY clocks and then every
// RPT_PER clocks.
module btn_step_decoder #(
  parameter int DB_CNT  = 1_000_000,
  parameter int RPT_DLY = 50_000_000,
  parameter int RPT_PER = 10_000_000
) (
  input  logic i_clk_fpga,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_dn,
  output logic step_up,
  output logic step_dn,
  output logic held
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DB_PRESS = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;
  localparam logic [1:0] DB_REL   = 2'd3;

  localparam logic [26:0] DB_LAST = 27'(DB_CNT - 1);
  localparam logic [26:0] T_MAX   = '1;

  // The synchronizers hold the inverted (active-high) level, so clearing
  // them on reset reads as "not pressed".
  logic [1:0] up_sync, dn_sync;
  logic       up_s, dn_s;

  logic [1:0]  state, state_nx;
  logic        dir, dir_nx;       // 0 = up, 1 = down
  logic [26:0] timer, timer_nx;
  logic        fire;              // a step is emitted on the next edge
  logic        sel, oth;          // latched button / the other button

  assign up_s = up_sync[1];
  assign dn_s = dn_sync[1];
  assign sel  = dir ? dn_s : up_s;
  assign oth  = dir ? up_s : dn_s;

`ifdef AUTO_REPEAT_EN
  logic [26:0] rpt, rpt_nx;
  logic        rpt_first, rpt_first_nx;  // initial delay already served
  localparam logic [26:0] RPT_DLY_LAST = 27'(RPT_DLY - 1);
  localparam logic [26:0] RPT_PER_LAST = 27'(RPT_PER - 1);
`endif

  // Two-flop synchronizers with inversion to active-high
  always_ff @(posedge i_clk_fpga or posedge reset) begin
    if (reset) begin
      up_sync <= 2'b00;
      dn_sync <= 2'b00;
    end else begin
      up_sync <= {up_sync[0], ~btn_up};
      dn_sync <= {dn_sync[0], ~btn_dn};
    end
  end

  // Next-state, timer and step-request logic
  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    timer_nx = timer;
    fire     = 1'b0;
`ifdef AUTO_REPEAT_EN
    rpt_nx       = rpt;
    rpt_first_nx = rpt_first;
`endif
    case (state)
      IDLE: begin
        if (up_s ^ dn_s) begin
          dir_nx   = dn_s;
          timer_nx = '0;
          state_nx = DB_PRESS;
        end
      end
      DB_PRESS: begin
        if (!sel || oth) begin
          state_nx = IDLE;
        end else if (timer == DB_LAST) begin
          state_nx = HOLD;
          fire     = 1'b1;
`ifdef AUTO_REPEAT_EN
          rpt_nx       = '0;
          rpt_first_nx = 1'b0;
`endif
        end else begin
          timer_nx = (timer == T_MAX) ? timer : timer + 27'd1;
        end
      end
      HOLD: begin
        // The other button is deliberately ignored while holding.
        if (!sel) begin
          timer_nx = '0;
          state_nx = DB_REL;
        end else begin
`ifdef AUTO_REPEAT_EN
          if (rpt == (rpt_first ? RPT_PER_LAST : RPT_DLY_LAST)) begin
            fire         = 1'b1;
            rpt_nx       = '0;
            rpt_first_nx = 1'b1;
          end else begin
            rpt_nx = (rpt == T_MAX) ? rpt : rpt + 27'd1;
          end
`endif
        end
      end
      default: begin  // DB_REL; repeat timer frozen here
        if (sel) begin
          state_nx = HOLD;
`ifdef AUTO_REPEAT_EN
          rpt_nx       = '0;
          rpt_first_nx = 1'b0;
`endif
        end else if (timer == DB_LAST) begin
          state_nx = IDLE;
        end else begin
          timer_nx = (timer == T_MAX) ? timer : timer + 27'd1;
        end
      end
    endcase
  end

  // FSM state, timers and registered outputs
  always_ff @(posedge i_clk_fpga or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      dir     <= 1'b0;
      timer   <= '0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
      held    <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt       <= '0;
      rpt_first <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      dir     <= dir_nx;
      timer   <= timer_nx;
      step_up <= fire & ~dir_nx;
      step_dn <= fire &  dir_nx;
      held    <= (state_nx == HOLD) || (state_nx == DB_REL);
`ifdef AUTO_REPEAT_EN
      rpt       <= rpt_nx;
      rpt_first <= rpt_first_nx;
`endif
    end
  end

endmodule

// File: tb/tb_btn_step_decoder.sv
// Directed bench for btn_step_decoder with DB_CNT=4, RPT_DLY=20, RPT_PER=8.
// Cycle 0 of each scenario is the cycle in which the raw inputs first change.
module tb_btn_step_decoder;

  logic clk = 1'b0;
  logic rst;
  logic btn_up, btn_dn;
  logic step_up, step_dn, held;

  btn_step_decoder #(.DB_CNT(4), .RPT_DLY(20), .RPT_PER(8)) dut (
    .i_clk_fpga(clk),
    .reset     (rst),
    .btn_up    (btn_up),
    .btn_dn    (btn_dn),
    .step_up   (step_up),
    .step_dn   (step_dn),
    .held      (held)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int   rel;
  int   up_t[$];
  int   dn_t[$];
  int   both;
  int   held_any;
  logic held_log [0:255];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, sample the outputs at the falling edge.
  task automatic tick(input logic u, input logic d, input logic r);
    btn_up = u;
    btn_dn = d;
    rst    = r;
    @(negedge clk);
    if (step_up) up_t.push_back(rel);
    if (step_dn) dn_t.push_back(rel);
    if (step_up && step_dn) both++;
    if (held) held_any++;
    if (rel < 256) held_log[rel] = held;
    rel++;
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rel = 0;
    up_t.delete();
    dn_t.delete();
    both = 0;
    held_any = 0;
    for (int i = 0; i < 256; i++) held_log[i] = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b1, 1'b0);
    clr();
  endtask

  int cnt;

  initial begin
    btn_up = 1'b1;
    btn_dn = 1'b1;
    rst    = 1'b1;
    clr();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_step_up", int'(step_up), 0);
    chk("rst_step_dn", int'(step_dn), 0);
    chk("rst_held",    int'(held),    0);
    @(posedge clk); #1;
    settle();

    // Single press held 30 cycles
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'b0);
`ifdef AUTO_REPEAT_EN
    chk("a_up_count", up_t.size(), 2);
    if (up_t.size() == 2) chk("a_up_rpt_t", up_t[1], 27);
`else
    chk("a_up_count", up_t.size(), 1);
`endif
    if (up_t.size() > 0) chk("a_up_t", up_t[0], 7);
    chk("a_dn_count", dn_t.size(), 0);
    chk("a_held6",  int'(held_log[6]),  0);
    chk("a_held7",  int'(held_log[7]),  1);
    chk("a_held36", int'(held_log[36]), 1);
    chk("a_held37", int'(held_log[37]), 0);
    settle();

    // 3-cycle bounce on down button
    for (int i = 0; i < 3; i++)  tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b1, 1'b0);
    chk("b_dn_count", dn_t.size(), 0);
    chk("b_up_count", up_t.size(), 0);
    chk("b_held_any", held_any, 0);
    settle();

    // Both buttons together
    for (int i = 0; i < 50; i++) tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0);
    chk("c_up_count", up_t.size(), 0);
    chk("c_dn_count", dn_t.size(), 0);
    chk("c_held_any", held_any, 0);
    settle();

    // Down held, short release glitch, press again
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)  tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b1, 1'b0);
    chk("d_dn_count", dn_t.size(), 1);
    if (dn_t.size() > 0) chk("d_dn_t", dn_t[0], 7);
    chk("d_up_count", up_t.size(), 0);
    cnt = 0;
    for (int i = 7; i <= 38; i++) if (held_log[i]) cnt++;
    chk("d_held_span", cnt, 32);
    chk("d_held39", int'(held_log[39]), 0);
    settle();

    // Long hold: auto-repeat pattern when enabled
    for (int i = 0; i < 50; i++) tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b1, 1'b0);
`ifdef AUTO_REPEAT_EN
    chk("e_up_count", up_t.size(), 5);
    if (up_t.size() == 5) begin
      chk("e_t1", up_t[1], 27);
      chk("e_t2", up_t[2], 35);
      chk("e_t3", up_t[3], 43);
      chk("e_t4", up_t[4], 51);
    end
`else
    chk("e_up_count", up_t.size(), 1);
`endif
    if (up_t.size() > 0) chk("e_t0", up_t[0], 7);
    chk("e_both", both, 0);
    settle();

    // Reset pulse mid-debounce (cycle 5), released in cycle 6
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b1, (i == 5) ? 1'b1 : 1'b0);
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b1, 1'b0);
    chk("f_up_count", up_t.size(), 1);
    if (up_t.size() > 0) chk("f_up_t", up_t[0], 13);
    chk("f_held5",  int'(held_log[5]),  0);
    chk("f_held7",  int'(held_log[7]),  0);
    chk("f_held13", int'(held_log[13]), 1);
    chk("f_dn_count", dn_t.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_step_decoder.md
BTN_STEP_DECODER -- requirements
Module: btn_step_decoder

Interface
REQ-001 Parameter DB_CNT, default 1_000_000, debounce length in clocks (10 ms at 100 MHz); range 2..2^27-1.
REQ-002 Parameter RPT_DLY, default 50_000_000, hold time before the first auto-repeat step; range 2..2^27-1.
REQ-003 Parameter RPT_PER, default 10_000_000, auto-repeat period in clocks; range 2..2^27-1.
REQ-004 i_clk_fpga  input  1  100 MHz system clock; the only clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 btn_up  input  1  raw, asynchronous, active-low "count up" push-button.
REQ-007 btn_dn  input  1  raw, asynchronous, active-low "count down" push-button.
REQ-008 step_up  output  1  one-cycle registered pulse: increment the counter by one.
REQ-009 step_dn  output  1  one-cycle registered pulse: decrement the counter by one.
REQ-010 held  output  1  registered; high while a debounced press is held (states HOLD and DB_REL).

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer and be inverted to active-high up_s/dn_s.
REQ-012 The FSM SHALL have four states: IDLE, DB_PRESS, HOLD, DB_REL; a shared timer is 27 bits wide and saturates, never wraps.
REQ-013 In IDLE, exactly one of up_s/dn_s high SHALL latch the direction, clear the timer and enter DB_PRESS; both high or neither high SHALL stay in IDLE.
REQ-014 In DB_PRESS, the timer SHALL increment each cycle while the latched button is high and the other button is low.
REQ-015 In DB_PRESS, release of the latched button or assertion of the other button SHALL return to IDLE with no step.
REQ-016 When the timer equals DB_CNT-1 with the press still valid, the FSM SHALL enter HOLD and pulse the latched step output on the next cycle.
REQ-017 The first step SHALL therefore go high DB_CNT+3 clocks after the raw input falls.
REQ-018 In HOLD, deassertion of the latched button SHALL clear the timer and enter DB_REL; the other button SHALL be ignored.
REQ-019 In DB_REL, the timer SHALL count while the button stays released; reaching DB_CNT-1 SHALL enter IDLE.
REQ-020 In DB_REL, re-assertion of the button SHALL return to HOLD with no step and restart the repeat delay.
REQ-021 step_up and step_dn SHALL never be high in the same cycle, and each pulse SHALL last exactly one cycle.
REQ-022 held SHALL be high in HOLD and DB_REL and low otherwise.

Reset
REQ-023 Asserting reset SHALL immediately force IDLE, clear the timer, clear the repeat timer and clear both synchronizers.
REQ-024 During reset, step_up, step_dn and held SHALL be 0.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL emit no step.
REQ-026 After reset is released, a button already held low SHALL be treated as a new press: a full debounce, then one step.

Configuration
REQ-027 Macro AUTO_REPEAT_EN defined: in HOLD, a repeat timer starts at 0 on HOLD entry.
REQ-028 With AUTO_REPEAT_EN, the repeat timer SHALL emit a step RPT_DLY clocks after the initial step, then one step every RPT_PER clocks while in HOLD.
REQ-029 With AUTO_REPEAT_EN, the repeat timer SHALL freeze in DB_REL.
REQ-030 Macro AUTO_REPEAT_EN undefined: exactly one step per debounced press, no repeat logic present.
REQ-031 RPT_DLY and RPT_PER SHALL be ignored when AUTO_REPEAT_EN is undefined.

Verification (DB_CNT=4, RPT_DLY=20, RPT_PER=8)
REQ-032 btn_up low at cycle 0, held 30 cycles -> single step_up at cycle 7; held high cycles 7..~37 (repeat off).
REQ-033 btn_dn pulse low for 3 cycles (bounce) -> no step_dn; FSM back in IDLE.
REQ-034 btn_up and btn_dn low simultaneously for 50 cycles -> no step of either kind.
REQ-035 AUTO_REPEAT_EN defined, btn_up held 50 cycles -> step_up at cycles 7, 27, 35, 43, 51 and no others.
REQ-036 Hold btn_dn past cycle 7, release for 2 cycles, then press again -> exactly one step_dn, held stays 1 throughout.
REQ-037 reset pulsed at cycle 5 while btn_up is held -> no step at cycle 7; step_up appears DB_CNT+3 cycles after reset release.
